hyper_pipe_rx_fifo: RTL and testbench
=====================================

Name: hyper_pipe_rx_fifo

Overview:
- Elastic receive stage placed directly downstream of a fixed-latency reset-able hyper pipeline.
- The hyper pipeline has no backpressure. This block absorbs every in-flight word and presents a valid/ready interface to the consumer.
- It generates an early credit signal, `in_ready_early`, which is sent back upstream (normally through a return hyper pipeline). The source stops issuing while enough slack still remains for all data already in flight.

Parameters:
- WIDTH, 64, data width in bits.
- DEPTH, 32, FIFO entries; power of two, ≥ 4.
- RTT, 8, round-trip cycles from an `in_ready_early` edge at this block to the last in_valid beat it can still cause; includes this block's output register. Required: DEPTH > RTT (elaboration-time $error otherwise).
- THRESH, DEPTH-RTT, derived local value; not overridable.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat from the hyper pipeline output; no ready is returned on this path.
- in_data  in  WIDTH  payload.
- in_ready_early  out  1  registered credit to upstream; 1 = source may issue.
- out_valid  out  1  FIFO head is valid.
- out_data  out  WIDTH  FIFO head (show-ahead).
- out_ready  in  1  consumer accepts the head.
- occupancy  out  $clog2(DEPTH+1)  registered entry count.
- overflow  out  1  sticky error: a beat was dropped.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Pointers cleared; occupancy=0; out_valid=0; in_ready_early=0; overflow=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored entries. Beats arriving while rst=1 are ignored.
- in_ready_early goes to 1 on the first edge after rst deasserts.
- Storage: DEPTH×WIDTH array with log2(DEPTH)-bit read and write pointers that wrap modulo DEPTH. Full/empty is resolved by occupancy, not by pointer compare.
- pop = out_valid & out_ready.
- push:
  - push = in_valid & (occupancy < DEPTH | pop).
  - A simultaneous pop frees the slot, so a push into a full FIFO with a same-cycle pop is accepted.
- Drop: if in_valid & occupancy==DEPTH & !pop, the beat is discarded, no state changes except overflow<=1. overflow stays 1 until rst.
- occupancy_next = occupancy + push - pop; registered.
- out_valid = (occupancy != 0). out_data = mem[rd_ptr]. Both are driven from registers only; no combinational path from in_* to out_*.
- Latency:
  - A beat written at edge t is visible on out_valid/out_data after edge t. It can be popped in cycle t+1.
  - A push into an empty FIFO therefore has 1 cycle latency. There is no bypass.
- Simultaneous push and pop with occupancy==1: the head is popped, the new beat becomes the head next cycle, and occupancy stays 1.
- Credit: in_ready_early <= (occupancy_next < THRESH).
  - Registered; it reflects the same-cycle push/pop.
  - Hysteresis is not permitted.
- Guarantee: if upstream obeys in_ready_early with a round trip ≤ RTT, overflow never sets.
- out_data must be stable while out_valid=1 and out_ready=0.

Test Plan (WIDTH=8, DEPTH=16, RTT=4, THRESH=12):
- Reset then idle:
  - After rst deasserts, in_ready_early=1 one edge later.
  - out_valid=0, occupancy=0, overflow=0.
- Ordered pass-through:
  - Stimulus: push 0x01..0x05 back-to-back with out_ready=1.
  - Outputs appear in order 0x01..0x05, each one cycle after its push.
  - occupancy never exceeds 1.
- Credit threshold:
  - Stimulus: out_ready=0; push 12 beats.
  - in_ready_early falls on the edge where occupancy becomes 12.
  - Source model with RTT=4 sends 4 more beats: occupancy=16, overflow=0.
  - Drain one: in_ready_early stays 0 until occupancy_next=11, then rises.
- Full with simultaneous pop:
  - Stimulus: occupancy=16, in_valid=1, out_ready=1 same cycle.
  - Beat accepted, occupancy stays 16, overflow=0.
- Overflow:
  - Stimulus: occupancy=16, in_valid=1 (data 0xAA), out_ready=0.
  - 0xAA absent from the drained stream; overflow=1 and held until rst.
- Wrap and mid-run reset:
  - Stream 40 beats with random out_ready: order preserved across pointer wrap.
  - Assert rst with occupancy=7: next cycle out_valid=0, occupancy=0, overflow=0, in_ready_early=0.

Source files
------------

// File: rtl/hyper_pipe_rx_fifo.sv
// hyper_pipe_rx_fifo
//   Elastic receive FIFO that sits directly behind a hyper pipeline that has
//   no backpressure. Every in-flight beat is absorbed into a DEPTH-entry
//   memory. The consumer sees a registered show-ahead valid/ready interface.
//   An early credit, in_ready_early, tells the source to stop issuing while
//   RTT slots of slack are still free.
//
// Ports
//   clk            single clock
//   rst            synchronous, active-high reset
//   in_valid       beat from the hyper pipeline (cannot be stalled)
//   in_data        payload of that beat
//   in_ready_early registered credit to upstream, 1 = source may issue
//   out_valid      FIFO head is valid (registered)
//   out_data       FIFO head, show-ahead (registered)
//   out_ready      consumer accepts the head
//   occupancy      registered entry count, 0..DEPTH
//   overflow       sticky: a beat arrived while full with no pop and was lost
module hyper_pipe_rx_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  parameter int RTT   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready_early,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       overflow
);

  localparam int AW     = $clog2(DEPTH);
  localparam int OW     = $clog2(DEPTH + 1);
  localparam int THRESH = DEPTH - RTT;

  localparam logic [OW-1:0] DEPTH_C  = OW'(DEPTH);
  localparam logic [OW-1:0] THRESH_C = OW'(THRESH);

  // Parameter sanity, reported at elaboration.
  if (DEPTH <= RTT) begin : g_bad_rtt
    $error("hyper_pipe_rx_fifo: DEPTH (%0d) must exceed RTT (%0d)", DEPTH, RTT);
  end
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("hyper_pipe_rx_fifo: DEPTH (%0d) must be a power of two >= 4", DEPTH);
  end

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [OW-1:0]    occ_reg;
  logic [OW-1:0]    occ_next;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             ready_reg;
  logic             overflow_reg;

  logic pop;
  logic push;
  logic drop;
  logic head_is_new;

  always_comb begin
    pop         = out_valid_reg & out_ready;
    // A same-cycle pop frees a slot, so a full FIFO still accepts.
    push        = in_valid & ((occ_reg != DEPTH_C) | pop);
    drop        = in_valid & ~push;
    occ_next    = occ_reg + {{(OW-1){1'b0}}, push} - {{(OW-1){1'b0}}, pop};
    rd_ptr_next = rd_ptr_reg + {{(AW-1){1'b0}}, pop};
    // The incoming beat becomes the head next cycle when nothing else
    // remains after this cycle's pop (empty, or occupancy 1 with pop).
    head_is_new = push & (occ_reg == {{(OW-1){1'b0}}, pop});
  end

  // Storage: write port only, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  // Registered show-ahead read. The address is the next head pointer, and
  // a beat that is about to become the head is forwarded from in_data
  // because the memory write lands on the same edge. With no pop the
  // address is unchanged and that entry is never rewritten, so out_data
  // holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (head_is_new) begin
      out_data_reg <= in_data;
    end else begin
      out_data_reg <= mem[rd_ptr_next];
    end
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      occ_reg       <= '0;
      out_valid_reg <= 1'b0;
      ready_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      rd_ptr_reg    <= rd_ptr_next;
      occ_reg       <= occ_next;
      out_valid_reg <= (occ_next != '0);
      // Credit follows the post-update count directly, no hysteresis.
      ready_reg     <= (occ_next < THRESH_C);
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign in_ready_early = ready_reg;
  assign out_valid      = out_valid_reg;
  assign out_data       = out_data_reg;
  assign occupancy      = occ_reg;
  assign overflow       = overflow_reg;

endmodule

// File: tb/tb_hyper_pipe_rx_fifo.sv
module tb_hyper_pipe_rx_fifo;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int RTT    = 4;
  localparam int THRESH = DEPTH - RTT;
  localparam int OW     = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready_early;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [OW-1:0]    occupancy;
  logic             overflow;

  hyper_pipe_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RTT(RTT)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready_early (in_ready_early),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .occupancy      (occupancy),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: beats the bench expects to come out, in order.
  logic [WIDTH-1:0] sb_q[$];
  logic             ovf_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".occupancy"}, 32'(occupancy), 32'(sb_q.size()));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(sb_q.size() != 0));
    check({tag, ".overflow"}, 32'(overflow), 32'(ovf_m));
    check({tag, ".ready_early"}, 32'(in_ready_early), 32'(sb_q.size() < THRESH));
  endtask

  // One clock of traffic. Called right after a negedge; drives inputs,
  // checks the head, advances one edge and checks the resulting state.
  task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d,
                      input logic r);
    logic pop_m;
    logic push_m;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    pop_m     = r && (sb_q.size() != 0);
    push_m    = v && ((sb_q.size() < DEPTH) || pop_m);
    if (sb_q.size() != 0) begin
      check({tag, ".head"}, 32'(out_data), 32'(sb_q[0]));
    end
    $display("%s: in_valid=%0b in_data=0x%02h out_ready=%0b pop=%0b push=%0b occ=%0d",
             tag, v, d, r, pop_m, push_m, sb_q.size());
    @(posedge clk);
    if (pop_m) void'(sb_q.pop_front());
    if (push_m) sb_q.push_back(d);
    if (v && !push_m) ovf_m = 1'b1;
    @(negedge clk);
    check_state(tag);
  endtask

  // Reset pulse for one edge (with an ignored beat offered), then release.
  task automatic do_reset(input string tag);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    out_ready = 1'b0;
    @(posedge clk);
    sb_q.delete();
    ovf_m = 1'b0;
    @(negedge clk);
    check({tag, ".rst.out_valid"}, 32'(out_valid), 32'(0));
    check({tag, ".rst.occupancy"}, 32'(occupancy), 32'(0));
    check({tag, ".rst.overflow"}, 32'(overflow), 32'(0));
    check({tag, ".rst.ready_early"}, 32'(in_ready_early), 32'(0));
    $display("%s: reset applied", tag);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_state({tag, ".post_rst"});
  endtask

  initial begin
    int sent;
    int guard;

    // Reset then idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    do_reset("reset");
    step("idle", 1'b0, 8'h00, 1'b0);

    // Ordered pass-through: occupancy never exceeds 1.
    for (int i = 1; i <= 5; i++) begin
      step("pass", 1'b1, 8'(i), 1'b1);
      check("pass.occ_le1", 32'(occupancy <= 1), 32'(1));
    end
    step("pass.tail", 1'b0, 8'h00, 1'b1);

    // Credit threshold: 12 beats trip the credit, RTT more land in flight.
    for (int i = 0; i < THRESH; i++) step("credit.fill", 1'b1, 8'(8'h10 + i), 1'b0);
    check("credit.fell", 32'(in_ready_early), 32'(0));
    for (int i = 0; i < RTT; i++) step("credit.inflight", 1'b1, 8'(8'h20 + i), 1'b0);
    check("credit.full_occ", 32'(occupancy), 32'(DEPTH));
    check("credit.no_ovf", 32'(overflow), 32'(0));

    // Full with simultaneous pop: accepted, stays full.
    step("full_pop", 1'b1, 8'h33, 1'b1);
    check("full_pop.occ", 32'(occupancy), 32'(DEPTH));

    // Overflow: 0xAA dropped, flag sticks.
    step("ovf", 1'b1, 8'hAA, 1'b0);
    check("ovf.flag", 32'(overflow), 32'(1));

    // Drain: credit stays low until occupancy_next reaches 11.
    guard = 0;
    while (sb_q.size() != 0 && guard < 40) begin
      step("drain", 1'b0, 8'h00, 1'b1);
      guard++;
    end
    check("drain.empty", 32'(sb_q.size()), 32'(0));
    step("drain.hold_ovf", 1'b0, 8'h00, 1'b1);

    // Wrap: 40 beats with random consumer stalls.
    do_reset("wrap");
    sent  = 0;
    guard = 0;
    while (sent < 40 && guard < 1000) begin
      logic v;
      v = (sb_q.size() < DEPTH);
      step("wrap", v, 8'(8'h40 + sent), 1'($urandom_range(0, 1)));
      if (v) sent++;
      guard++;
    end
    check("wrap.sent", 32'(sent), 32'(40));
    guard = 0;
    while (sb_q.size() != 0 && guard < 40) begin
      step("wrap.drain", 1'b0, 8'h00, 1'b1);
      guard++;
    end
    check("wrap.empty", 32'(sb_q.size()), 32'(0));

    // Mid-run reset with 7 entries stored.
    for (int i = 0; i < 7; i++) step("pre_rst", 1'b1, 8'(8'h70 + i), 1'b0);
    check("pre_rst.occ", 32'(occupancy), 32'(7));
    do_reset("midrst");
    step("after_rst", 1'b1, 8'hC3, 1'b0);
    step("after_rst.pop", 1'b0, 8'h00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
